// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce and ghost-key rejection.
//
// Drives one column at a time and samples the synchronized row lines at the end of each
// column's dwell. A single active row latches the key and starts a debounce count. A key
// is accepted only after DEBOUNCE_CNT consecutive stable cycles. It is released only after
// DEBOUNCE_CNT consecutive all-zero cycles.
//
// Parameters:
//   SCAN_DIV     : clk cycles each column is driven while scanning (>= 4)
//   DEBOUNCE_CNT : consecutive stable cycles to accept a press or a release (>= 2)
// Ports:
//   clk       : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   rows      : keypad row lines, active high, asynchronous to clk
//   columns   : one-hot column drive, bit0 = column of keys 1/4/7/*
//   keycode   : code of the last accepted key
//   key_valid : one-cycle pulse when a new press is accepted
//   key_held  : high from press acceptance until release acceptance
module keypad_scanner #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 20000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [3:0] keycode,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DwellW = $clog2(SCAN_DIV);
  localparam int unsigned DebW   = $clog2(DEBOUNCE_CNT);

  typedef enum logic [1:0] {StScan, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q;
  logic [3:0]        sync_q;
  logic [3:0]        rs_q;
  logic [3:0]        row_q;
  logic [DwellW-1:0] dwell_q;
  logic [DebW-1:0]   deb_q;

  logic       rs_onehot;
  logic       dwell_last;
  logic       deb_last;
  logic [3:0] col_next;

  // Bit position of a one-hot nibble (0 for anything else).
  function automatic logic [1:0] onehot_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Key legend lookup: column index in the high pair, row index in the low pair.
  function automatic logic [3:0] key_lookup(input logic [3:0] col, input logic [3:0] row);
    logic [3:0] code;
    case ({onehot_idx(col), onehot_idx(row)})
      4'h0: code = 4'h1;
      4'h1: code = 4'h4;
      4'h2: code = 4'h7;
      4'h3: code = 4'hE;
      4'h4: code = 4'h2;
      4'h5: code = 4'h5;
      4'h6: code = 4'h8;
      4'h7: code = 4'h0;
      4'h8: code = 4'h3;
      4'h9: code = 4'h6;
      4'hA: code = 4'h9;
      4'hB: code = 4'hF;
      4'hC: code = 4'hA;
      4'hD: code = 4'hB;
      4'hE: code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Zero or several active rows mean no key or a possible ghost; only one row is accepted.
  assign rs_onehot  = (rs_q != 4'b0000) && ((rs_q & (rs_q - 4'd1)) == 4'b0000);
  assign dwell_last = (dwell_q == DwellW'(SCAN_DIV - 1));
  assign deb_last   = (deb_q == DebW'(DEBOUNCE_CNT - 1));
  assign col_next   = {columns[2:0], columns[3]};

  // Two-flop synchronizer for the asynchronous row lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 4'b0000;
      rs_q   <= 4'b0000;
    end else begin
      sync_q <= rows;
      rs_q   <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StScan;
      columns   <= 4'b0001;
      dwell_q   <= '0;
      deb_q     <= '0;
      row_q     <= 4'b0000;
      keycode   <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state_q)
        StScan: begin
          if (dwell_last) begin
            // Dwell restarts at zero; it stays zero while scanning is suspended.
            dwell_q <= '0;
            if (rs_onehot) begin
              row_q   <= rs_q;
              deb_q   <= '0;
              state_q <= StDebounce;
            end else begin
              columns <= col_next;
            end
          end else begin
            dwell_q <= dwell_q + DwellW'(1);
          end
        end
        StDebounce: begin
          if (rs_q == row_q) begin
            if (deb_last) begin
              state_q   <= StPressed;
              keycode   <= key_lookup(columns, row_q);
              key_held  <= 1'b1;
              key_valid <= 1'b1;
            end else begin
              deb_q <= deb_q + DebW'(1);
            end
          end else begin
            state_q <= StScan;
            columns <= col_next;
          end
        end
        StPressed: begin
          if (rs_q != row_q) begin
            deb_q   <= '0;
            state_q <= StRelease;
          end
        end
        StRelease: begin
          // A bounce back to the latched row only restarts the count; no re-press.
          if (rs_q == 4'b0000) begin
            if (deb_last) begin
              key_held <= 1'b0;
              state_q  <= StScan;
              columns  <= col_next;
            end else begin
              deb_q <= deb_q + DebW'(1);
            end
          end else begin
            deb_q <= '0;
          end
        end
        default: state_q <= StScan;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=8).
// A keypad model turns pressed keys into row levels from the driven column. A behavioural
// reference tracks what the scanner must show, and every output is compared each cycle.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [3:0] rows = 4'b0000;
  logic [3:0] columns;
  logic [3:0] keycode;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV    (SD),
    .DEBOUNCE_CNT(DB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rows     (rows),
    .columns  (columns),
    .keycode  (keycode),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // ---------------- keypad model (stimulus) ----------------
  logic [15:0] pressed = 16'h0;  // bit c*4+r = key at column c, row r
  logic        use_raw = 1'b0;
  logic [3:0]  raw_rows = 4'b0000;

  always @(negedge clk) begin
    if (use_raw) begin
      rows = raw_rows;
    end else begin
      logic [3:0] r;
      r = 4'b0000;
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++)
          if (pressed[c*4+k] && columns[c]) r[k] = 1'b1;
      rows = r;
    end
  end

  // ---------------- behavioural reference ----------------
  localparam int MScan = 0, MConfirm = 1, MHold = 2, MRelease = 3;
  // Legend per column (row 0..3).
  int         legend [16] = '{4'h1, 4'h4, 4'h7, 4'hE, 4'h2, 4'h5, 4'h8, 4'h0,
                              4'h3, 4'h6, 4'h9, 4'hF, 4'hA, 4'hB, 4'hC, 4'hD};
  logic [3:0] m_s1, m_rs, m_cur, m_row;
  int         m_mode, m_col, m_dwell, m_cnt, m_key;
  logic       m_valid, m_held;

  function automatic int row_of(input logic [3:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 4; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = 0; m_rs = 0; m_row = 0; m_mode = MScan; m_col = 0; m_dwell = 0;
      m_cnt = 0; m_key = 0; m_valid = 0; m_held = 0;
    end else begin
      m_cur = m_rs;  // decisions use what was synchronized before this edge
      m_rs = m_s1;
      m_s1 = rows;
      m_valid = 0;
      case (m_mode)
        MScan: begin
          if (m_dwell == SD - 1) begin
            m_dwell = 0;
            if ($countones(m_cur) == 1) begin
              m_row = m_cur; m_cnt = 0; m_mode = MConfirm;
            end else m_col = (m_col + 1) % 4;
          end else m_dwell++;
        end
        MConfirm: begin
          if (m_cur == m_row) begin
            if (m_cnt == DB - 1) begin
              m_mode = MHold; m_key = legend[m_col*4 + row_of(m_row)];
              m_held = 1; m_valid = 1;
            end else m_cnt++;
          end else begin
            m_mode = MScan; m_col = (m_col + 1) % 4;
          end
        end
        MHold: if (m_cur != m_row) begin m_cnt = 0; m_mode = MRelease; end
        default: begin
          if (m_cur == 0) begin
            if (m_cnt == DB - 1) begin
              m_held = 0; m_mode = MScan; m_col = (m_col + 1) % 4;
            end else m_cnt++;
          end else m_cnt = 0;
        end
      endcase
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic       chk_en = 1'b0;
  logic       prev_valid = 1'b0;
  int         pulses = 0;
  logic [3:0] codes[$];
  logic [3:0] one = 4'b0001;

  always @(negedge clk) begin
    if (chk_en) begin
      check("columns", columns, one << m_col);
      check("keycode", keycode, 4'(m_key));
      check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      check("key_held", {3'b0, key_held}, {3'b0, m_held});
      check("valid_back_to_back", {3'b0, key_valid & prev_valid}, 4'h0);
      if (key_valid) begin
        pulses++;
        codes.push_back(keycode);
      end
      prev_valid = key_valid;
    end
  end

  // ---------------- helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    idle(1);
  endtask

  task automatic press(input int c, input int r);
    pressed = 16'h0;
    pressed[c*4+r] = 1'b1;
  endtask

  task automatic wait_cols(input logic [3:0] target, input int budget);
    int n;
    n = 0;
    while (columns !== target && n < budget) begin
      idle(1);
      n++;
    end
    if (columns !== target) begin
      errors++;
      checks++;
      $display("FAIL wait_columns got %h want %h", columns, target);
    end
  endtask

  task automatic wait_confirm(input int budget);
    int n;
    n = 0;
    while (m_mode != MConfirm && n < budget) begin
      idle(1);
      n++;
    end
    check_int("reach_debounce", m_mode, MConfirm);
  endtask

  logic [3:0] sweep_exp [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

  initial begin
    int p0, q0, k;
    #1 reset_n = 1'b0;
    #1;
    check("reset_columns", columns, 4'b0001);
    check("reset_keycode", keycode, 4'h0);
    check("reset_valid", {3'b0, key_valid}, 4'h0);
    check("reset_held", {3'b0, key_held}, 4'h0);
    idle(2);
    reset_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Key 5 pressed while column 0010 is driven, held 100 cycles.
    wait_cols(4'b0010, 40);
    p0 = pulses;
    press(1, 1);
    idle(100);
    check("held_during_press", {3'b0, key_held}, 4'h1);
    pressed = 16'h0;
    idle(30);
    check_int("press5_pulses", pulses - p0, 1);
    check("press5_code", keycode, 4'h5);
    check("press5_released", {3'b0, key_held}, 4'h0);

    // Short 5-cycle glitch on row 3 during column 1000: rejected.
    do_reset();
    wait_cols(4'b1000, 40);
    p0 = pulses;
    use_raw = 1'b1;
    raw_rows = 4'b1000;
    idle(5);
    raw_rows = 4'b0000;
    idle(30);
    use_raw = 1'b0;
    check_int("glitch_pulses", pulses - p0, 0);
    check("glitch_code", keycode, 4'h0);

    // Two rows at once: never accepted, scanning continues.
    do_reset();
    p0 = pulses;
    use_raw = 1'b1;
    raw_rows = 4'b0011;
    idle(60);
    use_raw = 1'b0;
    raw_rows = 4'b0000;
    check_int("multi_row_pulses", pulses - p0, 0);

    // '#' with bouncing release.
    do_reset();
    p0 = pulses;
    press(2, 3);
    idle(60);
    pressed = 16'h0;
    use_raw = 1'b1;
    repeat (3) begin
      raw_rows = 4'b0000; idle(3);
      raw_rows = 4'b1000; idle(3);
    end
    check("bounce_still_held", {3'b0, key_held}, 4'h1);
    raw_rows = 4'b0000;
    idle(20);
    use_raw = 1'b0;
    check("bounce_released", {3'b0, key_held}, 4'h0);
    check_int("hash_pulses", pulses - p0, 1);
    check("hash_code", keycode, 4'hF);

    // Reset in the middle of debounce.
    do_reset();
    press(1, 1);
    idle(60);
    pressed = 16'h0;
    idle(30);
    check("pre_reset_code", keycode, 4'h5);
    p0 = pulses;
    press(0, 0);
    wait_confirm(40);
    idle(2);
    reset_n = 1'b0;
    #1;
    check("midreset_columns", columns, 4'b0001);
    check("midreset_keycode", keycode, 4'h0);
    check("midreset_valid", {3'b0, key_valid}, 4'h0);
    check("midreset_held", {3'b0, key_held}, 4'h0);
    pressed = 16'h0;
    idle(2);
    reset_n = 1'b1;
    idle(20);
    check_int("midreset_pulses", pulses - p0, 0);

    // Sweep all 16 keys row by row.
    do_reset();
    q0 = codes.size();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        press(c, r);
        idle(60);
        pressed = 16'h0;
        idle(40);
      end
    check_int("sweep_count", codes.size() - q0, 16);
    for (int i = 0; i < 16; i++)
      if (q0 + i < codes.size()) check($sformatf("sweep_%0d", i), codes[q0+i], sweep_exp[i]);

    // Randomized presses, ghosts, noise and resets against the reference.
    for (int it = 0; it < 120; it++) begin
      k = $urandom_range(0, 9);
      if (k == 0) begin
        reset_n = 1'b0;
        idle($urandom_range(1, 3));
        reset_n = 1'b1;
        idle(1);
      end else if (k <= 2) begin
        use_raw = 1'b1;
        repeat ($urandom_range(1, 20)) begin
          raw_rows = 4'($urandom);
          idle(1);
        end
        use_raw = 1'b0;
      end else begin
        press($urandom_range(0, 3), $urandom_range(0, 3));
        if (k == 3) pressed[$urandom_range(0, 15)] = 1'b1;
        idle($urandom_range(1, 50));
        pressed = 16'h0;
        idle($urandom_range(1, 40));
      end
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
